// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - GF arithmetic helpers, affine and basis-change matrices for the Canright S-box
// Encoding: GF(2^2) {W^2,W}, GF(2^4) {Z^4,Z} over GF(2^2), GF(2^8) {Y^16,Y} over GF(2^4).
package aes_sbox_pkg;

    typedef logic [7:0][7:0] mat8_t;

    localparam logic [7:0] AFF_FWD_C = 8'h63;
    localparam logic [7:0] AFF_INV_C = 8'h05;

    // Row i is the mask of input bits XORed into output bit i.
    localparam mat8_t AFF_FWD_M = {8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1};
    localparam mat8_t AFF_INV_M = {8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4};

    function automatic logic [7:0] mat_vec(input mat8_t m, input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            y[i] = ^(m[i] & x);
        end
        return y;
    endfunction

    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic p;
        p = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ p, (a[0] & b[0]) ^ p};
    endfunction

    // Multiply by N = W^2.
    function automatic logic [1:0] gf2_scl_n(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // In this normal basis squaring and inversion are both a coordinate swap.
    function automatic logic [1:0] gf2_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        e = gf2_scl_n(gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {gf2_mul(a[3:2], b[3:2]) ^ e, gf2_mul(a[1:0], b[1:0]) ^ e};
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [1:0] theta;
        logic [1:0] theta_inv;
        theta     = gf2_mul(a[3:2], a[1:0]) ^ gf2_scl_n(gf2_sq(a[3:2] ^ a[1:0]));
        theta_inv = gf2_sq(theta);
        return {gf2_mul(theta_inv, a[1:0]), gf2_mul(theta_inv, a[3:2])};
    endfunction

    // First nu for which t^2 + t + nu has no root in GF(2^4).
    function automatic logic [3:0] find_nu();
        logic [3:0] nu;
        logic       found;
        logic       has_root;
        logic [3:0] x;
        logic [3:0] n;
        nu    = 4'h0;
        found = 1'b0;
        for (int k = 1; k < 16; k++) begin
            n        = k[3:0];
            has_root = 1'b0;
            for (int j = 0; j < 16; j++) begin
                x = j[3:0];
                if ((gf4_mul(x, x) ^ x) == n) begin
                    has_root = 1'b1;
                end
            end
            if (!found && !has_root) begin
                nu    = n;
                found = 1'b1;
            end
        end
        return nu;
    endfunction

    localparam logic [3:0] GF4_NU = find_nu();

    function automatic logic [3:0] gf4_sq_scl(input logic [3:0] a);
        return gf4_mul(gf4_mul(a, a), GF4_NU);
    endfunction

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] e;
        e = gf4_mul(gf4_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), GF4_NU);
        return {gf4_mul(a[7:4], b[7:4]) ^ e, gf4_mul(a[3:0], b[3:0]) ^ e};
    endfunction

    // Image of the AES element x: a composite-field root of x^8+x^4+x^3+x+1 (one is 8'hFF).
    function automatic logic [7:0] find_root();
        logic [7:0] c;
        logic [7:0] c2;
        logic [7:0] c3;
        logic [7:0] c4;
        logic [7:0] c8;
        logic [7:0] r;
        logic       found;
        r     = 8'h00;
        found = 1'b0;
        for (int i = 1; i < 256; i++) begin
            c  = i[7:0];
            c2 = gf8_mul(c, c);
            c3 = gf8_mul(c2, c);
            c4 = gf8_mul(c2, c2);
            c8 = gf8_mul(c4, c4);
            if (!found && ((c8 ^ c4 ^ c3 ^ c ^ 8'hFF) == 8'h00)) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic mat8_t build_p2n(input logic [7:0] root);
        mat8_t      m;
        logic [7:0] pw;
        m  = '0;
        pw = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 8; r++) begin
                m[r][i] = pw[r];
            end
            pw = gf8_mul(pw, root);
        end
        return m;
    endfunction

    function automatic mat8_t mat_inv(input mat8_t m);
        mat8_t      a;
        mat8_t      b;
        logic [7:0] ta;
        logic [7:0] tb;
        int         sel;
        logic       found;
        a = m;
        for (int r = 0; r < 8; r++) begin
            b[r] = 8'h01 << r;
        end
        for (int col = 0; col < 8; col++) begin
            sel   = col;
            found = 1'b0;
            for (int p = col; p < 8; p++) begin
                if (!found && a[p][col]) begin
                    sel   = p;
                    found = 1'b1;
                end
            end
            ta = a[col]; a[col] = a[sel]; a[sel] = ta;
            tb = b[col]; b[col] = b[sel]; b[sel] = tb;
            for (int r = 0; r < 8; r++) begin
                if (r != col && a[r][col]) begin
                    a[r] = a[r] ^ a[col];
                    b[r] = b[r] ^ b[col];
                end
            end
        end
        return b;
    endfunction

    localparam logic [7:0] ISO_ROOT = find_root();
    localparam mat8_t      P2N_M    = build_p2n(ISO_ROOT);
    localparam mat8_t      N2P_M    = mat_inv(P2N_M);

endpackage

// File: rtl/aes_sbox_canright_inv.sv
// rtl/aes_sbox_canright_inv.sv - combinational GF(2^8) inverter in the Canright normal basis
module gf256_inv_canright (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_sbox_pkg::*;

    logic [3:0] g1;
    logic [3:0] g0;
    logic [3:0] theta;
    logic [3:0] theta_inv;

    // Zero input gives theta = 0, whose inverse is 0, so Inv(0) = 0 falls out.
    always_comb begin
        g1        = a[7:4];
        g0        = a[3:0];
        theta     = gf4_mul(g1, g0) ^ gf4_sq_scl(g1 ^ g0);
        theta_inv = gf4_inv(theta);
        y         = {gf4_mul(theta_inv, g0), gf4_mul(theta_inv, g1)};
    end

endmodule

// File: rtl/aes_sbox_canright.sv
// rtl/aes_sbox_canright.sv - registered AES forward/inverse S-box, one byte per cycle
module aes_sbox_canright (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_in,
    input  logic       encrypt,
    input  logic [7:0] A,
    output logic [7:0] Q,
    output logic       valid_out
);
    import aes_sbox_pkg::*;

    logic [7:0] pre_aff;
    logic [7:0] inv_in;
    logic [7:0] nb_in;
    logic [7:0] nb_out;
    logic [7:0] pb_out;
    logic [7:0] q_d;
    logic [7:0] q_q;
    logic       valid_d;
    logic       valid_q;

    always_comb begin
        pre_aff = mat_vec(AFF_INV_M, A) ^ AFF_INV_C;
        inv_in  = encrypt ? A : pre_aff;
        nb_in   = mat_vec(P2N_M, inv_in);
    end

    gf256_inv_canright u_inv (
        .a (nb_in),
        .y (nb_out)
    );

    always_comb begin
        pb_out  = mat_vec(N2P_M, nb_out);
        q_d     = encrypt ? (mat_vec(AFF_FWD_M, pb_out) ^ AFF_FWD_C) : pb_out;
        valid_d = valid_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q     <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q         = q_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_aes_sbox_canright.sv
// tb/tb_aes_sbox_canright.sv - scoreboard bench for aes_sbox_canright
module tb_aes_sbox_canright;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_in;
    logic       encrypt;
    logic [7:0] A;
    logic [7:0] Q;
    logic       valid_out;

    always #5 clk = ~clk;

    aes_sbox_canright dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .encrypt   (encrypt),
        .A         (A),
        .Q         (Q),
        .valid_out (valid_out)
    );

    typedef struct {
        logic [7:0] q;
        logic       v;
        string      ph;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [0:255][7:0] sbox_fwd;
    logic [7:0]        sbox_inv [256];

    task automatic drive(input logic rst, input logic v, input logic enc, input logic [7:0] a,
                         input logic [7:0] eq, input logic ev, input string ph);
        exp_t e;
        @(negedge clk);
        reset_n  = rst;
        valid_in = v;
        encrypt  = enc;
        A        = a;
        e.q  = eq;
        e.v  = ev;
        e.ph = ph;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (valid_out !== e.v || Q !== e.q) begin
                    failures++;
                    $display("FAIL %s: Q=%02h valid_out=%0b expected Q=%02h valid_out=%0b",
                             e.ph, Q, valid_out, e.q, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete, pending=%0d expected 0", sb.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        logic [7:0] ca [4];
        logic [7:0] cq [4];
        logic [7:0] fb;
        logic       enc;
        int         wait_cyc;

        reset_n  = 1'b0;
        valid_in = 1'b0;
        encrypt  = 1'b1;
        A        = 8'h00;

        sbox_fwd = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) begin
            sbox_inv[sbox_fwd[i]] = i[7:0];
        end

        drive(1'b0, 1'b1, 1'b1, 8'h53, 8'h00, 1'b0, "reset_hold0");
        drive(1'b0, 1'b1, 1'b1, 8'h53, 8'h00, 1'b0, "reset_hold1");
        drive(1'b1, 1'b1, 1'b1, 8'h53, 8'hED, 1'b1, "reset_release");

        ca = '{8'h00, 8'h01, 8'h53, 8'hFF};
        cq = '{8'h63, 8'h7C, 8'hED, 8'h16};
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, ca[i], cq[i], 1'b1, "fwd_corner");

        ca = '{8'h63, 8'h00, 8'hED, 8'h16};
        cq = '{8'h00, 8'h52, 8'h53, 8'hFF};
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, ca[i], cq[i], 1'b1, "inv_corner");

        for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, 1'b1, i[7:0], sbox_fwd[i], 1'b1, "sweep_fwd");
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, 1'b0, i[7:0], sbox_inv[i], 1'b1, "sweep_inv");

        for (int k = 0; k < 8; k++) begin
            enc = ~k[0];
            drive(1'b1, 1'b1, enc, 8'h53, enc ? 8'hED : 8'h50, 1'b1, "toggle");
        end

        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h63, 1'b1, "gap_before");
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h7C, 1'b1, "gap_before");
        drive(1'b1, 1'b0, 1'b1, 8'h53, 8'hED, 1'b0, "gap_slot");
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h16, 1'b1, "gap_after");

        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 1'b1, i[7:0], sbox_fwd[i], 1'b1, "rt_fwd");
            @(posedge clk);
            #1;
            fb = Q;
            drive(1'b1, 1'b1, 1'b0, fb, i[7:0], 1'b1, "rt_inv");
        end

        @(negedge clk);
        valid_in = 1'b0;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
